addertree_accum_pipe: RTL and testbench
=======================================

Name: addertree_accum_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width compression stages of the MAC adder tree.
- Reduces N_IN product terms per beat to one sum through registered binary levels.
- Accumulates beats until a last-marked beat, then emits one result per group (kernel window).
- Adds signed/unsigned mode, optional saturation with an overflow flag, and valid/ready backpressure; sits between the multiplier array and the output/activation unit.

Parameters:
N_IN, 9, product terms per beat (e.g. 3x3 kernel)
IN_W, 16, width of each product term
ACC_W, 32, accumulator and output width; must be >= IN_W+LEVELS
SAT, 0, 1 = saturate accumulation, 0 = wrap modulo 2^ACC_W
LEVELS (localparam), max(1, clog2(N_IN)), tree register levels

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  beat present
in_ready  output  1  beat accepted when in_valid & in_ready
in_data  input  N_IN*IN_W  products, term k at [k*IN_W +: IN_W]
in_last  input  1  beat closes the current group
mode_signed  input  1  1 = two's-complement terms/accumulation, 0 = unsigned; travels with the beat
out_valid  output  1  group result present
out_ready  input  1  downstream accepts result
out_data  output  ACC_W  group sum
out_ovf  output  1  sticky: overflow or saturation occurred in this group

Behaviour:
- Global enable en = ~out_valid | out_ready. in_ready = en. When en=0, every pipeline register, valid bit, and the accumulator hold.
- Tree level l (1..LEVELS) registers ceil(N_IN/2^l) partial sums of width IN_W+l.
  - Pairs are added after sign extension (mode_signed=1) or zero extension (mode_signed=0).
  - An unpaired odd element is extended and passed through unchanged.
- valid, last and mode_signed are pipelined alongside the data through each level.
- Accumulate stage, when en=1 and tree output valid: sum = acc + extend(tree_out) at ACC_W+1 bits.
  - SAT=1, signed: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SAT=1, unsigned: clamp to [0, 2^ACC_W-1].
  - SAT=0: wrap modulo 2^ACC_W.
  - ovf_this = the result left the representable range (signed or unsigned per beat mode).
  - grp_ovf accumulates ovf_this for the group.
- Non-last beat: acc <= result; grp_ovf <= grp_ovf | ovf_this; out_valid unchanged.
- Last beat: out_data <= result; out_ovf <= grp_ovf | ovf_this; out_valid <= 1; acc <= 0; grp_ovf <= 0. The next group starts from 0.
- out_valid clears on out_valid & out_ready unless a new last beat completes in the same cycle, in which case it stays 1 with new data.
- Latency: with no stall, the last beat accepted in cycle t gives out_valid=1 in cycle t+LEVELS+1. Throughput is one beat per cycle.
- Single-beat group: legal (in_last=1 on first beat); result equals that beat's tree sum.
- Reset values: in_ready=1 after deassert (out_valid=0); out_valid=0; out_data=0; out_ovf=0; acc=0; all pipeline valids=0.
- Reset mid-group discards all in-flight beats and partial accumulation; no stale result is ever emitted.
- Mode changing inside a group: each beat is extended and checked per its own mode. The group result is defined but meaningful only when mode is constant within the group.
- in_data, in_last and mode_signed are ignored when in_valid=0 or in_ready=0.

Test Plan:
- Defaults, signed: one beat, all nine terms = 1, in_last=1, out_ready=1 -> out_valid pulses one cycle exactly 5 cycles later, out_data=9, out_ovf=0.
- Defaults: nine terms 16'hFFFF, last. With mode_signed=1 -> out_data=32'hFFFFFFF7 (-9). With mode_signed=0 -> out_data=589815.
- Three back-to-back beats, all terms=100, in_last on the third -> one result 2700. A following single beat of all 1s -> 9, with no carry-over.
- out_ready held 0 while out_valid=1 and input streaming -> in_ready=0, out_data stable, no beat dropped. Release -> all subsequent group sums correct and in order.
- SAT=1, ACC_W=20, signed: two beats of nine 32767 (294903 each), last on second -> out_data=524287, out_ovf=1. Same with SAT=0 -> out_data=20'h8FFEE (-458770), out_ovf=1. Next clean group -> out_ovf=0.
- Two beats of all 100 accepted, reset pulsed for one cycle, then one last beat of all 1s -> out_data=9; no output during or immediately after reset.

Source files
------------

// File: rtl/addertree_accum_pipe.sv
// Pipelined adder tree that reduces N_IN product terms per beat, then accumulates
// beats into one group sum with optional saturation and a sticky overflow flag.
module addertree_accum_pipe #(
  parameter int N_IN  = 9,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int SAT   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   in_last,
  input  logic                   mode_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_ovf
);

  localparam int LEVELS = (N_IN > 2) ? $clog2(N_IN) : 1;
  localparam int TW     = IN_W + LEVELS;
  localparam int NP     = 2 * N_IN;

  function automatic int unsigned cnt_at(input int unsigned l);
    return (N_IN + (1 << l) - 1) >> l;
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Every level is carried at full tree width; terms are extended once at the
  // input per the beat's mode, so wider levels hold the same value as IN_W+l.
  logic [TW-1:0]   node [0:LEVELS][NP];
  logic [TW-1:0]   tq   [1:LEVELS][NP];
  logic [LEVELS:1] tv, tl, tm;

  always_comb begin
    for (int unsigned l = 0; l <= LEVELS; l++)
      for (int unsigned k = 0; k < NP; k++)
        node[l][k] = '0;
    for (int unsigned k = 0; k < N_IN; k++)
      node[0][k] = {{(TW-IN_W){mode_signed & in_data[k*IN_W+IN_W-1]}},
                    in_data[k*IN_W +: IN_W]};
    for (int unsigned l = 1; l <= LEVELS; l++)
      for (int unsigned k = 0; k < NP; k++)
        node[l][k] = tq[l][k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned l = 1; l <= LEVELS; l++)
        for (int unsigned k = 0; k < NP; k++)
          tq[l][k] <= '0;
      tv <= '0;
      tl <= '0;
      tm <= '0;
    end else if (en) begin
      tv[1] <= in_valid;
      tl[1] <= in_last;
      tm[1] <= mode_signed;
      for (int unsigned l = 2; l <= LEVELS; l++) begin
        tv[l] <= tv[l-1];
        tl[l] <= tl[l-1];
        tm[l] <= tm[l-1];
      end
      for (int unsigned l = 1; l <= LEVELS; l++) begin
        for (int unsigned k = 0; k < N_IN; k++) begin
          if (2*k + 1 < cnt_at(l-1))
            tq[l][k] <= node[l-1][2*k] + node[l-1][2*k+1];
          else if (2*k < cnt_at(l-1))
            tq[l][k] <= node[l-1][2*k];
          else
            tq[l][k] <= '0;
        end
        for (int unsigned k = N_IN; k < NP; k++)
          tq[l][k] <= '0;
      end
    end
  end

  logic [ACC_W-1:0] acc;
  logic             grp_ovf;
  logic [TW-1:0]    tree_out;
  logic             m;
  logic [ACC_W:0]   a_ext, t_ext, sum;
  logic [ACC_W-1:0] res;
  logic             ovf;

  assign tree_out = tq[LEVELS][0];
  assign m        = tm[LEVELS];

  always_comb begin
    a_ext = {m & acc[ACC_W-1], acc};
    t_ext = {{(ACC_W+1-TW){m & tree_out[TW-1]}}, tree_out};
    sum   = a_ext + t_ext;
    ovf   = m ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    res   = sum[ACC_W-1:0];
    // Unsigned operands are both non-negative, so only the upper bound can be hit.
    if (SAT != 0 && ovf) begin
      if (m)
        res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        res = '1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      grp_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= 1'b0;
      if (tv[LEVELS]) begin
        if (tl[LEVELS]) begin
          out_data  <= res;
          out_ovf   <= grp_ovf | ovf;
          out_valid <= 1'b1;
          acc       <= '0;
          grp_ovf   <= 1'b0;
        end else begin
          acc     <= res;
          grp_ovf <= grp_ovf | ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_addertree_accum_pipe.sv
// Scoreboard bench: three instances (32-bit wrap, 20-bit saturate, 20-bit wrap)
// share one input stream and are checked against an integer-arithmetic model.
module tb_addertree_accum_pipe;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [143:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         mode_signed = 1'b0;
  logic         out_ready = 1'b1;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
  logic [31:0] od0;
  logic [19:0] od1, od2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_acc = 0;

  logic [32:0] q0[$], q1[$], q2[$];
  longint      macc [3];
  bit          mgovf [3];
  int          aws [3];
  bit          sats [3];
  logic [31:0] last_d [3];
  bit          last_o [3];
  bit          stall_prev = 1'b0;
  logic [31:0] stall_d = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  addertree_accum_pipe #(.N_IN(9), .IN_W(16), .ACC_W(32), .SAT(0)) u_def (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .mode_signed(mode_signed), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_ovf(of0));
  addertree_accum_pipe #(.N_IN(9), .IN_W(16), .ACC_W(20), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .mode_signed(mode_signed), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_ovf(of1));
  addertree_accum_pipe #(.N_IN(9), .IN_W(16), .ACC_W(20), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .mode_signed(mode_signed), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .out_ovf(of2));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [143:0] fill9(input logic [15:0] v);
    logic [143:0] d;
    for (int k = 0; k < 9; k++) d[k*16 +: 16] = v;
    return d;
  endfunction

  // Reference: group sum per beat as plain integers, then range rules per config.
  task automatic model_accept(input logic [143:0] d, input bit last, input bit sm);
    longint bv, modv, a, s, lo, hi, r;
    bit o;
    logic [15:0] t;
    logic [32:0] e;
    bv = 0;
    for (int k = 0; k < 9; k++) begin
      t = d[k*16 +: 16];
      bv += sm ? longint'($signed(t)) : longint'(t);
    end
    for (int c = 0; c < 3; c++) begin
      modv = 64'sd1 <<< aws[c];
      a = macc[c];
      if (sm && a >= modv / 2) a -= modv;
      s  = a + bv;
      lo = sm ? -(modv / 2) : 0;
      hi = sm ? (modv / 2 - 1) : (modv - 1);
      o  = (s < lo) || (s > hi);
      r  = s;
      if (sats[c] && o) r = (s < lo) ? lo : hi;
      r = r & (modv - 1);
      if (last) begin
        e[31:0] = r[31:0];
        e[32]   = o | mgovf[c];
        if (c == 0) q0.push_back(e);
        else if (c == 1) q1.push_back(e);
        else q2.push_back(e);
        macc[c]  = 0;
        mgovf[c] = 1'b0;
      end else begin
        macc[c]  = r;
        mgovf[c] = mgovf[c] | o;
      end
    end
  endtask

  // Input side: record accepted beats into the model.
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        macc[c] = 0;
        mgovf[c] = 1'b0;
      end
    end else begin
      if (rdy0 !== rdy1 || rdy0 !== rdy2) chk("in_ready_agree", {rdy0, rdy1, rdy2}, {rdy0, rdy0, rdy0});
      if (in_valid && rdy0) begin
        t_acc = cyc;
        model_accept(in_data, in_last, mode_signed);
      end
    end
  end

  task automatic pop_cmp(input int c, input logic [31:0] d, input bit o);
    logic [32:0] e;
    bit empty;
    empty = (c == 0) ? (q0.size() == 0) : (c == 1) ? (q1.size() == 0) : (q2.size() == 0);
    if (empty) begin
      chk($sformatf("unexpected_out_%0d", c), 1, 0);
    end else begin
      e = (c == 0) ? q0.pop_front() : (c == 1) ? q1.pop_front() : q2.pop_front();
      chk($sformatf("out_data_%0d", c), longint'(d), longint'(e[31:0]));
      chk($sformatf("out_ovf_%0d", c), longint'(o), longint'(e[32]));
      last_d[c] = d;
      last_o[c] = o;
    end
  endtask

  // Output side: compare each presented result against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (ov0 && out_ready) pop_cmp(0, od0, of0);
      if (ov1 && out_ready) pop_cmp(1, {12'd0, od1}, of1);
      if (ov2 && out_ready) pop_cmp(2, {12'd0, od2}, of2);
      if (ov0 && !out_ready) begin
        if (stall_prev) chk("stall_hold", longint'(od0), longint'(stall_d));
        chk("in_ready_stall", longint'(rdy0), 0);
        stall_prev = 1'b1;
        stall_d = od0;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [143:0] d, input bit last, input bit sm);
    bit ok;
    in_data = d;
    in_last = last;
    mode_signed = sm;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rdy0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = fill9(16'($urandom));
    in_last = 1'($urandom);
    mode_signed = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
    end
    chk("drain", longint'(q0.size() + q1.size() + q2.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [143:0] rand_data();
    logic [143:0] d;
    int sel;
    sel = $urandom_range(0, 3);
    for (int k = 0; k < 9; k++)
      d[k*16 +: 16] = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : 16'($urandom);
    return d;
  endfunction

  initial begin
    #20000000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    aws = '{32, 20, 20};
    sats = '{1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      macc[c] = 0;
      mgovf[c] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", longint'(ov0), 0);
    chk("rst_out_data", longint'(od0), 0);
    chk("rst_out_ovf", longint'(of0), 0);
    chk("rst_in_ready", longint'(rdy0), 1);
    @(posedge clk);
    #1;

    // Single beat of ones: latency and one-cycle pulse.
    send_beat(fill9(16'd1), 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov0) break;
    end
    chk("latency", longint'(cyc - t_acc), 5);
    @(negedge clk);
    chk("pulse_width", longint'(ov0), 0);
    drain();
    chk("ones_sum", longint'(last_d[0]), 9);

    send_beat(fill9(16'hFFFF), 1'b1, 1'b1);
    drain();
    chk("neg9_signed", longint'(last_d[0]), 64'hFFFFFFF7);
    send_beat(fill9(16'hFFFF), 1'b1, 1'b0);
    drain();
    chk("ffff_unsigned", longint'(last_d[0]), 589815);

    send_beat(fill9(16'd100), 1'b0, 1'b1);
    send_beat(fill9(16'd100), 1'b0, 1'b1);
    send_beat(fill9(16'd100), 1'b1, 1'b1);
    send_beat(fill9(16'd1), 1'b1, 1'b1);
    drain();
    chk("no_carry_over", longint'(last_d[0]), 9);

    // Overflow group: saturating and wrapping 20-bit instances.
    send_beat(fill9(16'd32767), 1'b0, 1'b1);
    send_beat(fill9(16'd32767), 1'b1, 1'b1);
    drain();
    chk("sat_data", longint'(last_d[1]), 524287);
    chk("sat_ovf", longint'(last_o[1]), 1);
    chk("wrap_data", longint'(last_d[2]), 64'h8FFEE);
    chk("wrap_ovf", longint'(last_o[2]), 1);
    chk("wide_no_ovf", longint'(last_o[0]), 0);
    send_beat(fill9(16'd5), 1'b1, 1'b1);
    drain();
    chk("clean_ovf_sat", longint'(last_o[1]), 0);

    // Backpressure: hold out_ready low while groups stream in.
    out_ready = 1'b0;
    fork
      begin
        send_beat(fill9(16'd100), 1'b1, 1'b1);
        send_beat(fill9(16'd3), 1'b0, 1'b0);
        send_beat(fill9(16'd4), 1'b1, 1'b0);
        send_beat(fill9(16'hFFFF), 1'b1, 1'b1);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_last", longint'(last_d[0]), 64'hFFFFFFF7);

    // Reset mid-group discards the partial sum.
    send_beat(fill9(16'd100), 1'b0, 1'b1);
    send_beat(fill9(16'd100), 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("in_reset_valid", longint'(ov0), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_valid", longint'({ov0, ov1, ov2}), 0);
    end
    @(posedge clk);
    #1;
    send_beat(fill9(16'd1), 1'b1, 1'b1);
    drain();
    chk("after_reset_sum", longint'(last_d[0]), 9);

    // Randomized groups with random gaps and backpressure.
    done = 1'b0;
    fork
      begin
        for (int g = 0; g < 60; g++) begin
          int nb;
          bit sm;
          nb = $urandom_range(1, 4);
          sm = 1'($urandom);
          for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
            send_beat(rand_data(), b == nb - 1, sm);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
